// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush to NOP bubbles, and a saturating decode-stall counter.
module if_id_pipe_reg #(
   parameter int unsigned                INSTR_W     = 32,
   parameter int unsigned                PC_W        = 32,
   parameter logic [INSTR_W-1:0]         NOP_INSTR   = '0,
   parameter int unsigned                STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INSTR_W-1:0]     instruction_in,
   input  logic [PC_W-1:0]        npc_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INSTR_W-1:0]     instruction_out,
   output logic [PC_W-1:0]        npc_out,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   logic                   out_valid_q, out_valid_d;
   logic [INSTR_W-1:0]     out_instr_q, out_instr_d;
   logic [PC_W-1:0]        out_npc_q,   out_npc_d;
   logic                   skid_valid_q, skid_valid_d;
   logic [INSTR_W-1:0]     skid_instr_q, skid_instr_d;
   logic [PC_W-1:0]        skid_npc_q,   skid_npc_d;
   logic                   in_ready_q,  in_ready_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic in_fire_c;
   logic slot_free_c;

   assign in_fire_c   = in_valid & in_ready_q;
   assign slot_free_c = ~out_valid_q | out_ready;

   // Output slot / skid slot next-state; the skid entry always drains before newer input.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_instr_d  = out_instr_q;
      out_npc_d    = out_npc_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_npc_d   = skid_npc_q;
      stall_cnt_d  = stall_cnt_q;

      if (flush) begin
         out_valid_d  = 1'b0;
         out_instr_d  = NOP_INSTR;
         skid_valid_d = 1'b0;
      end else if (slot_free_c) begin
         if (skid_valid_q) begin
            // in_ready is low whenever the skid is full, so no input can fire here
            out_valid_d  = 1'b1;
            out_instr_d  = skid_instr_q;
            out_npc_d    = skid_npc_q;
            skid_valid_d = 1'b0;
         end else if (in_fire_c) begin
            out_valid_d  = 1'b1;
            out_instr_d  = instruction_in;
            out_npc_d    = npc_in;
         end else begin
            out_valid_d  = 1'b0;
            out_instr_d  = NOP_INSTR;
         end
      end else if (in_fire_c) begin
         skid_valid_d = 1'b1;
         skid_instr_d = instruction_in;
         skid_npc_d   = npc_in;
      end

      if (out_valid_q && !out_ready && !flush && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   assign in_ready_d = ~skid_valid_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_instr_q  <= NOP_INSTR;
         out_npc_q    <= '0;
         skid_valid_q <= 1'b0;
         skid_instr_q <= '0;
         skid_npc_q   <= '0;
         in_ready_q   <= 1'b1;
         stall_cnt_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_instr_q  <= out_instr_d;
         out_npc_q    <= out_npc_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_npc_q   <= skid_npc_d;
         in_ready_q   <= in_ready_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign in_ready        = in_ready_q;
   assign out_valid       = out_valid_q;
   assign instruction_out = out_instr_q;
   assign npc_out         = out_npc_q;
   assign stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: directed vector table plus a queue-based reference
// model that every cycle predicts the presented entry, in_ready and stall counts.
module tb_if_id_pipe_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] instruction_in;
   logic [31:0] npc_in;

   logic        in_ready,  in_ready4;
   logic        out_valid, out_valid4;
   logic [31:0] instruction_out, instruction_out4;
   logic [31:0] npc_out, npc_out4;
   logic [15:0] stall_cnt;
   logic [3:0]  stall_cnt4;

   always #5 clk = ~clk;

   if_id_pipe_reg u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .instruction_in(instruction_in), .npc_in(npc_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .instruction_out(instruction_out), .npc_out(npc_out),
      .stall_cnt(stall_cnt)
   );

   // Narrow-counter instance for the saturation case; shares all inputs.
   if_id_pipe_reg #(.STALL_CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready4),
      .instruction_in(instruction_in), .npc_in(npc_in),
      .out_valid(out_valid4), .out_ready(out_ready),
      .instruction_out(instruction_out4), .npc_out(npc_out4),
      .stall_cnt(stall_cnt4)
   );

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] npc;
   } ent_t;

   typedef struct {
      logic        iv;
      logic        ordy;
      logic        fl;
      logic [31:0] ins;
      logic [31:0] npc;
      logic        e_v;
      logic [31:0] e_ins;
      logic [31:0] e_npc;
      logic        e_ir;
      logic [15:0] e_cnt;
   } vec_t;

   int          n_chk = 0;
   int          n_err = 0;
   ent_t        sb[$];
   logic        m_ir;
   logic [31:0] m_npc;
   logic [15:0] m_cnt;
   logic [3:0]  m_cnt4;
   vec_t        tbl[16];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_ir   = 1'b1;
      m_npc  = '0;
      m_cnt  = '0;
      m_cnt4 = '0;
   endtask

   task automatic check_model();
      ent_t f;
      f = (sb.size() > 0) ? sb[0] : '0;
      chk("sb out_valid", 64'(out_valid), 64'(sb.size() > 0));
      chk("sb instruction_out", 64'(instruction_out), (sb.size() > 0) ? 64'(f.ins) : 64'(0));
      chk("sb npc_out", 64'(npc_out), 64'(m_npc));
      chk("sb in_ready", 64'(in_ready), 64'(m_ir));
      chk("sb stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      chk("sb stall_cnt4", 64'(stall_cnt4), 64'(m_cnt4));
   endtask

   // Drive one cycle, advance the reference model at the edge, then compare.
   task automatic step(input logic iv, input logic ordy, input logic fl,
                       input logic [31:0] ins, input logic [31:0] npc);
      ent_t e;
      in_valid       = iv;
      out_ready      = ordy;
      flush          = fl;
      instruction_in = ins;
      npc_in         = npc;
      @(posedge clk);
      if (fl) begin
         sb.delete();
      end else begin
         if (sb.size() > 0 && !ordy) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt4 != 4'hF)    m_cnt4 = m_cnt4 + 4'd1;
         end
         if (sb.size() > 0 && ordy) void'(sb.pop_front());
         if (iv && m_ir) begin
            e.ins = ins;
            e.npc = npc;
            sb.push_back(e);
         end
      end
      m_ir = (sb.size() < 2);
      if (sb.size() > 0) m_npc = sb[0].npc;
      #1;
      check_model();
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instruction_in = '0; npc_in = '0;
      model_reset();

      #12;
      chk("reset out_valid", 64'(out_valid), 64'(0));
      chk("reset in_ready", 64'(in_ready), 64'(1));
      chk("reset instruction_out", 64'(instruction_out), 64'(0));
      chk("reset npc_out", 64'(npc_out), 64'(0));
      chk("reset stall_cnt", 64'(stall_cnt), 64'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Fill both slots, then reset between edges.
      step(1'b1, 1'b0, 1'b0, 32'hDEAD0001, 32'h200);
      step(1'b1, 1'b0, 1'b0, 32'hDEAD0002, 32'h204);
      chk("mid full in_ready", 64'(in_ready), 64'(0));
      #2 rst_n = 1'b0;
      #1;
      chk("async out_valid", 64'(out_valid), 64'(0));
      chk("async in_ready", 64'(in_ready), 64'(1));
      chk("async instruction_out", 64'(instruction_out), 64'(0));
      chk("async stall_cnt", 64'(stall_cnt), 64'(0));
      chk("async npc_out", 64'(npc_out), 64'(0));
      model_reset();
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      //            iv    ordy  fl    ins           npc      e_v   e_ins         e_npc    e_ir  e_cnt
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h8C010004, 32'h04, 1'b1, 32'h8C010004, 32'h04, 1'b1, 16'd0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h8C020008, 32'h08, 1'b1, 32'h8C020008, 32'h08, 1'b1, 16'd0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h8C03000C, 32'h0C, 1'b1, 32'h8C03000C, 32'h0C, 1'b1, 16'd0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h00221820, 32'h10, 1'b1, 32'h00221820, 32'h10, 1'b1, 16'd0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0,  1'b0, 32'h0,        32'h10, 1'b1, 16'd0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h11111111, 32'h100, 1'b1, 32'h11111111, 32'h100, 1'b1, 16'd0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h22222222, 32'h104, 1'b1, 32'h11111111, 32'h100, 1'b0, 16'd1};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h33333333, 32'h108, 1'b1, 32'h11111111, 32'h100, 1'b0, 16'd2};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h33333333, 32'h108, 1'b1, 32'h11111111, 32'h100, 1'b0, 16'd3};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h33333333, 32'h108, 1'b1, 32'h22222222, 32'h104, 1'b1, 16'd3};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h33333333, 32'h108, 1'b1, 32'h33333333, 32'h108, 1'b1, 16'd3};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 32'h0,        32'h108, 1'b1, 16'd3};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h44444444, 32'h10C, 1'b1, 32'h44444444, 32'h10C, 1'b1, 16'd3};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h55555555, 32'h110, 1'b1, 32'h44444444, 32'h10C, 1'b0, 16'd4};
      tbl[14] = '{1'b1, 1'b0, 1'b1, 32'h66666666, 32'h114, 1'b0, 32'h0,        32'h10C, 1'b1, 16'd4};
      tbl[15] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0,   1'b0, 32'h0,        32'h10C, 1'b1, 16'd4};

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].ins, tbl[i].npc);
         chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].e_v));
         chk($sformatf("vec%0d instruction_out", i), 64'(instruction_out), 64'(tbl[i].e_ins));
         chk($sformatf("vec%0d npc_out", i), 64'(npc_out), 64'(tbl[i].e_npc));
         chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
         chk($sformatf("vec%0d stall_cnt", i), 64'(stall_cnt), 64'(tbl[i].e_cnt));
      end

      // Saturation of the 4-bit counter under a long stall.
      step(1'b1, 1'b1, 1'b0, 32'h77777777, 32'h118);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("sat stall_cnt4", 64'(stall_cnt4), 64'(4'hF));
      chk("sat stall_cnt", 64'(stall_cnt), 64'(16'd24));
      chk("sat held instr", 64'(instruction_out), 64'(32'h77777777));

      // Random valid/ready/flush traffic against the reference model.
      for (int i = 0; i < 10000; i++) begin
         step(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 65),
              1'($urandom_range(0, 99) < 4), $urandom, $urandom);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      chk("drain empty", 64'(sb.size()), 64'(0));
      chk("drain out_valid", 64'(out_valid), 64'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
